// File: rtl/sram_access_ctrl_if.sv
// Bundles the requester handshake and the SRAM strobe/data lines of sram_access_ctrl.
// The slave view belongs to the controller; the master view is the requester plus SRAM side.
interface sram_access_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);

  logic              wr_req;
  logic              rd_req;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              wr_done;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic              sram_we;
  logic              sram_oe;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  wr_req,
    input  rd_req,
    input  addr,
    input  wdata,
    input  sram_rdata,
    output busy,
    output wr_done,
    output rdata,
    output rdata_valid,
    output sram_addr,
    output sram_wdata,
    output sram_we,
    output sram_oe
  );

  modport master (
    output wr_req,
    output rd_req,
    output addr,
    output wdata,
    output sram_rdata,
    input  busy,
    input  wr_done,
    input  rdata,
    input  rdata_valid,
    input  sram_addr,
    input  sram_wdata,
    input  sram_we,
    input  sram_oe
  );

endinterface

// File: rtl/sram_access_ctrl.sv
// Sequences single-cycle read/write requests into timed SRAM cycles (setup, WE pulse, hold,
// OE with wait states) and returns captured read data with a one-cycle valid pulse.
module sram_access_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int SETUP_CYC = 1,
  parameter int WE_CYC    = 1,
  parameter int RD_CYC    = 2
) (
  input  logic                clk,
  input  logic                n_rst,
  sram_access_ctrl_if.slave   bus
);

  // One shared down-counter; it is loaded with (cycles - 1) and the state ends when it reads zero.
  localparam int CNT_MAX_SW = (SETUP_CYC > WE_CYC) ? SETUP_CYC : WE_CYC;
  localparam int CNT_MAX    = (CNT_MAX_SW > RD_CYC) ? CNT_MAX_SW : RD_CYC;
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] WE_LD    = CNT_W'(WE_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LD    = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    WSETUP,
    WPULSE,
    WHOLD,
    RWAIT,
    RDONE
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic              accept_wr;
  logic              accept_rd;
  logic              capture;

  logic              busy_q;
  logic              wr_done_q;
  logic              rdata_valid_q;
  logic              we_q;
  logic              oe_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.wr_req) begin
          state_n   = WSETUP;
          cnt_n     = SETUP_LD;
          accept_wr = 1'b1;
        end else if (bus.rd_req) begin
          state_n   = RWAIT;
          cnt_n     = RD_LD;
          accept_rd = 1'b1;
        end
      end
      WSETUP: begin
        if (cnt == '0) begin
          state_n = WPULSE;
          cnt_n   = WE_LD;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      WPULSE: begin
        if (cnt == '0) begin
          state_n = WHOLD;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      WHOLD: begin
        state_n = IDLE;
      end
      RWAIT: begin
        if (cnt == '0) begin
          state_n = RDONE;
          capture = 1'b1;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      RDONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Strobes and flags are decoded from the next state so every output comes straight off a flop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      busy_q        <= 1'b0;
      wr_done_q     <= 1'b0;
      rdata_valid_q <= 1'b0;
      we_q          <= 1'b0;
      oe_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      busy_q        <= (state_n != IDLE);
      wr_done_q     <= (state_n == WHOLD);
      rdata_valid_q <= (state_n == RDONE);
      we_q          <= (state_n == WPULSE);
      oe_q          <= (state_n == RWAIT);
      if (accept_wr || accept_rd) begin
        addr_q <= bus.addr;
      end
      if (accept_wr) begin
        wdata_q <= bus.wdata;
      end
      if (capture) begin
        rdata_q <= bus.sram_rdata;
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.wr_done     = wr_done_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.sram_we     = we_q;
  assign bus.sram_oe     = oe_q;
  assign bus.sram_addr   = addr_q;
  assign bus.sram_wdata  = wdata_q;
  assign bus.rdata       = rdata_q;

  a_we_oe_exclusive : assert property (@(posedge clk) disable iff (!n_rst) !(we_q && oe_q));

  a_addr_stable : assert property (@(posedge clk) disable iff (!n_rst)
    (state != IDLE && $past(state) != IDLE) |-> ($stable(addr_q) && $stable(wdata_q)));

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed, table-driven bench for sram_access_ctrl with a single-word SRAM model behind it.
// Each vector drives inputs before a rising edge and checks the registered outputs just after.
module tb_sram_access_ctrl;

  logic clk;
  logic n_rst;

  sram_access_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  sram_access_ctrl #(
    .DATA_W(8), .ADDR_W(4), .SETUP_CYC(1), .WE_CYC(1), .RD_CYC(2)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-word SRAM: writes on a rising edge while sram_we is high, output always visible.
  logic [7:0] mem = 8'h00;
  always @(posedge clk) if (bus.sram_we) mem <= bus.sram_wdata;
  assign bus.sram_rdata = mem;

  typedef struct {
    logic       wr_req;
    logic       rd_req;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       we;
    logic       oe;
    logic       wr_done;
    logic       valid;
    logic [7:0] rdata;
    logic [3:0] s_addr;
    logic [7:0] s_wdata;
  } vec_t;

  vec_t vecs[$];
  int   vectors;
  int   miscompares;

  function automatic vec_t mk(input logic wr, input logic rd, input logic [3:0] a,
                              input logic [7:0] d, input logic b, input logic we,
                              input logic oe, input logic dn, input logic vl,
                              input logic [7:0] rd_d, input logic [3:0] sa,
                              input logic [7:0] sd);
    vec_t v;
    v.wr_req = wr; v.rd_req = rd; v.addr = a; v.wdata = d;
    v.busy = b; v.we = we; v.oe = oe; v.wr_done = dn; v.valid = vl;
    v.rdata = rd_d; v.s_addr = sa; v.s_wdata = sd;
    return v;
  endfunction

  task automatic checkField(input string tag, input string name, input int got, input int exp);
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s %s: got 0x%0h, expected 0x%0h", tag, name, got, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    vectors++;
    checkField(tag, "busy",        int'(bus.busy),        int'(v.busy));
    checkField(tag, "sram_we",     int'(bus.sram_we),     int'(v.we));
    checkField(tag, "sram_oe",     int'(bus.sram_oe),     int'(v.oe));
    checkField(tag, "wr_done",     int'(bus.wr_done),     int'(v.wr_done));
    checkField(tag, "rdata_valid", int'(bus.rdata_valid), int'(v.valid));
    checkField(tag, "rdata",       int'(bus.rdata),       int'(v.rdata));
    checkField(tag, "sram_addr",   int'(bus.sram_addr),   int'(v.s_addr));
    checkField(tag, "sram_wdata",  int'(bus.sram_wdata),  int'(v.s_wdata));
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.wr_req = v.wr_req;
    bus.rd_req = v.rd_req;
    bus.addr   = v.addr;
    bus.wdata  = v.wdata;
    @(posedge clk);
    #1;
  endtask

  vec_t zero_v;
  vec_t idle_v;
  int   n;

  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b0;
    bus.addr    = 4'h0;
    bus.wdata   = 8'h00;
    zero_v = mk(0,0,4'h0,8'h00, 0,0,0,0,0, 8'h00,4'h0,8'h00);

    // wr rd addr wdata | busy we oe done valid | rdata saddr swdata
    for (int i = 0; i < 5; i++) vecs.push_back(zero_v);
    vecs.push_back(mk(1,0,4'h3,8'h2A, 1,0,0,0,0, 8'h00,4'h3,8'h2A));
    vecs.push_back(mk(0,0,4'h0,8'h00, 1,1,0,0,0, 8'h00,4'h3,8'h2A));
    vecs.push_back(mk(0,0,4'h0,8'h00, 1,0,0,1,0, 8'h00,4'h3,8'h2A));
    vecs.push_back(mk(0,0,4'h0,8'h00, 0,0,0,0,0, 8'h00,4'h3,8'h2A));
    vecs.push_back(mk(0,1,4'h3,8'h00, 1,0,1,0,0, 8'h00,4'h3,8'h2A));
    vecs.push_back(mk(0,0,4'h0,8'h00, 1,0,1,0,0, 8'h00,4'h3,8'h2A));
    vecs.push_back(mk(0,0,4'h0,8'h00, 1,0,0,0,1, 8'h2A,4'h3,8'h2A));
    vecs.push_back(mk(0,0,4'h0,8'h00, 0,0,0,0,0, 8'h2A,4'h3,8'h2A));
    vecs.push_back(mk(1,1,4'h5,8'h55, 1,0,0,0,0, 8'h2A,4'h5,8'h55));
    vecs.push_back(mk(0,0,4'h0,8'h00, 1,1,0,0,0, 8'h2A,4'h5,8'h55));
    vecs.push_back(mk(0,0,4'h0,8'h00, 1,0,0,1,0, 8'h2A,4'h5,8'h55));
    vecs.push_back(mk(0,0,4'h0,8'h00, 0,0,0,0,0, 8'h2A,4'h5,8'h55));
    vecs.push_back(mk(0,1,4'h5,8'h00, 1,0,1,0,0, 8'h2A,4'h5,8'h55));
    vecs.push_back(mk(0,0,4'h0,8'h00, 1,0,1,0,0, 8'h2A,4'h5,8'h55));
    vecs.push_back(mk(0,0,4'h0,8'h00, 1,0,0,0,1, 8'h55,4'h5,8'h55));
    vecs.push_back(mk(0,0,4'h0,8'h00, 0,0,0,0,0, 8'h55,4'h5,8'h55));
    vecs.push_back(mk(1,0,4'h1,8'hA7, 1,0,0,0,0, 8'h55,4'h1,8'hA7));
    vecs.push_back(mk(0,1,4'h9,8'h00, 1,1,0,0,0, 8'h55,4'h1,8'hA7));
    vecs.push_back(mk(0,1,4'h9,8'h00, 1,0,0,1,0, 8'h55,4'h1,8'hA7));
    vecs.push_back(mk(0,0,4'h0,8'h00, 0,0,0,0,0, 8'h55,4'h1,8'hA7));
    vecs.push_back(mk(0,0,4'h0,8'h00, 0,0,0,0,0, 8'h55,4'h1,8'hA7));
    vecs.push_back(mk(0,1,4'h1,8'h00, 1,0,1,0,0, 8'h55,4'h1,8'hA7));
    vecs.push_back(mk(0,0,4'h0,8'h00, 1,0,1,0,0, 8'h55,4'h1,8'hA7));
    vecs.push_back(mk(1,0,4'h2,8'h3C, 1,0,0,0,1, 8'hA7,4'h1,8'hA7));
    vecs.push_back(mk(1,0,4'h2,8'h3C, 0,0,0,0,0, 8'hA7,4'h1,8'hA7));
    vecs.push_back(mk(1,0,4'h2,8'h3C, 1,0,0,0,0, 8'hA7,4'h2,8'h3C));
    vecs.push_back(mk(0,0,4'h0,8'h00, 1,1,0,0,0, 8'hA7,4'h2,8'h3C));
    vecs.push_back(mk(0,0,4'h0,8'h00, 1,0,0,1,0, 8'hA7,4'h2,8'h3C));
    vecs.push_back(mk(0,0,4'h0,8'h00, 0,0,0,0,0, 8'hA7,4'h2,8'h3C));

    // Reset held for two edges with outputs checked while it is asserted.
    n_rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checkOutput(zero_v, $sformatf("reset%0d", i));
    end
    @(negedge clk);
    n_rst = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset landing in the middle of the write strobe.
    applyStimulus(mk(1,0,4'h7,8'h99, 1,0,0,0,0, 8'hA7,4'h7,8'h99));
    checkOutput(mk(1,0,4'h7,8'h99, 1,0,0,0,0, 8'hA7,4'h7,8'h99), "midrst_setup");
    idle_v = mk(0,0,4'h0,8'h00, 1,1,0,0,0, 8'hA7,4'h7,8'h99);
    applyStimulus(idle_v);
    checkOutput(idle_v, "midrst_pulse");
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput(zero_v, "midrst_async");
    @(posedge clk);
    #1;
    checkOutput(zero_v, "midrst_held");
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(zero_v);
      checkOutput(zero_v, $sformatf("midrst_idle%0d", i));
    end

    // Bounded waits for completion: write latency, read latency and read-back value.
    idle_v = mk(1,0,4'h4,8'h11, 0,0,0,0,0, 8'h00,4'h0,8'h00);
    applyStimulus(idle_v);
    bus.wr_req = 1'b0;
    n = 1;
    while (!bus.wr_done && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    checkField("lat", "wr_done_cycle", n, 3);
    @(posedge clk);
    #1;
    idle_v = mk(0,1,4'h4,8'h00, 0,0,0,0,0, 8'h00,4'h0,8'h00);
    applyStimulus(idle_v);
    bus.rd_req = 1'b0;
    n = 1;
    while (!bus.rdata_valid && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    checkField("lat", "rdata_valid_cycle", n, 3);
    checkField("lat", "readback", int'(bus.rdata), 32'h11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Synchronous sequencer that sits directly upstream of sram_module and owns its strobes.
- Turns single-cycle write/read requests from the project datapath into correctly timed SRAM cycles: address/data setup, write-enable pulse, hold, and output-enable with read wait states.
- On reads it captures the SRAM output byte and presents it to the requester with a one-cycle valid pulse.

Parameters:
DATA_W, 8, SRAM data width
ADDR_W, 4, SRAM address width; the current single-word sram_module ignores sram_addr
SETUP_CYC, 1, cycles address/data are stable before sram_we rises (>=1)
WE_CYC, 1, cycles sram_we is held high (>=1)
RD_CYC, 2, cycles sram_oe is high before sram_rdata is sampled (>=1)

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
wr_req  input  1  write request, sampled only in IDLE
rd_req  input  1  read request, sampled only in IDLE
addr  input  ADDR_W  request address
wdata  input  DATA_W  write data
busy  output  1  high whenever state != IDLE
wr_done  output  1  one-cycle pulse, write complete
rdata  output  DATA_W  last captured read byte
rdata_valid  output  1  one-cycle pulse, rdata updated
sram_addr  output  ADDR_W  registered address to SRAM
sram_wdata  output  DATA_W  registered data to SRAM inData
sram_we  output  1  SRAM writeEnable
sram_oe  output  1  SRAM outputEnable
sram_rdata  input  DATA_W  SRAM outData

Behaviour:
- Reset (n_rst low, asynchronous, may occur mid-operation): state goes to IDLE and the counter clears. All outputs go to 0 immediately, including sram_we, sram_oe, busy, wr_done, rdata_valid, rdata, sram_addr and sram_wdata. No partial cycle resumes after reset release.
- All outputs are registered; none depend combinationally on inputs.
- States: IDLE, WSETUP, WPULSE, WHOLD, RWAIT, RDONE. A single down-counter sized to the largest of SETUP_CYC, WE_CYC and RD_CYC times each state.
- IDLE
  - wr_req=1 at an edge: latch addr into sram_addr and wdata into sram_wdata, load the counter, go to WSETUP.
  - Otherwise rd_req=1 at an edge: latch addr, go to RWAIT with sram_oe=1.
  - wr_req and rd_req together: write wins; the read is dropped.
- WSETUP: sram_we=0 for SETUP_CYC cycles, then WPULSE.
- WPULSE: sram_we=1 for exactly WE_CYC cycles, then WHOLD.
- WHOLD: sram_we=0, sram_addr/sram_wdata unchanged, wr_done=1 for this single cycle, then IDLE.
- RWAIT: sram_oe=1 for RD_CYC cycles. At the edge ending the last RWAIT cycle, capture sram_rdata into rdata and go to RDONE.
- RDONE: sram_oe=0, rdata_valid=1 for one cycle, then IDLE.
- rdata holds its value until the next read capture.
- Requests are ignored while busy=1; there is no queueing and the requester must retry.
- Back-to-back requests: a request present in the first IDLE cycle after completion is accepted at that edge. Minimum one IDLE cycle between operations.
- sram_we and sram_oe are never high in the same cycle.
- sram_addr and sram_wdata change only on acceptance in IDLE, so they are stable through every strobe.
- Write latency (accept edge to busy low) = SETUP_CYC+WE_CYC+1 cycles; with defaults, 3.
- Read latency = RD_CYC+1 cycles; with defaults, 3.

Test Plan:
- Reset then idle: hold n_rst=0 for 2 cycles, release, no requests for 5 cycles -> all outputs 0, busy=0 throughout.
- Single write: wdata=8'h2A, wr_req pulsed 1 cycle -> sram_wdata=8'h2A from the next cycle; sram_we high exactly 1 cycle, 1 cycle after acceptance; wr_done pulses 1 cycle later; busy high for 3 cycles.
- Write then read: write 8'h2A, then rd_req -> sram_oe high 2 cycles, rdata=8'h2A with rdata_valid high 1 cycle, sram_we=0 during the read.
- Simultaneous wr_req=1 and rd_req=1 with wdata=8'h55 -> write sequence only, no sram_oe, no rdata_valid; a subsequent read returns 8'h55.
- Request while busy: rd_req asserted during WPULSE -> ignored, no read occurs after the write completes; wr_done still pulses once.
- Mid-operation reset: n_rst=0 asynchronously while sram_we=1 -> sram_we, busy and sram_wdata go to 0 before the next clock edge; after release the block sits in IDLE with no wr_done.
